// File: rtl/vga_timing_pkg.sv
// ----------------------------------------------------------------------------
// vga_timing_pkg
//   Shared timing constants for 640x480@60 VGA and the coordinate type used by
//   the counter and the timing generator.
//
//   Horizontal (pixels): visible 0-639, front porch 640-655,
//                        sync 656-751, back porch 752-799, total 800.
//   Vertical   (lines) : visible 0-479, front porch 480-489,
//                        sync 490-491, back porch 492-524, total 525.
// ----------------------------------------------------------------------------
package vga_timing_pkg;

    typedef logic [9:0] coord_t;

    // Horizontal segment lengths
    localparam coord_t H_VISIBLE = 10'd640;
    localparam coord_t H_FRONT   = 10'd16;
    localparam coord_t H_SYNC    = 10'd96;
    localparam coord_t H_BACK    = 10'd48;
    localparam coord_t H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

    // Vertical segment lengths
    localparam coord_t V_VISIBLE = 10'd480;
    localparam coord_t V_FRONT   = 10'd10;
    localparam coord_t V_SYNC    = 10'd2;
    localparam coord_t V_BACK    = 10'd33;
    localparam coord_t V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    // Inclusive sync windows derived from the segment lengths
    localparam coord_t H_SYNC_START = H_VISIBLE + H_FRONT;
    localparam coord_t H_SYNC_END   = H_SYNC_START + H_SYNC - coord_t'(1);
    localparam coord_t V_SYNC_START = V_VISIBLE + V_FRONT;
    localparam coord_t V_SYNC_END   = V_SYNC_START + V_SYNC - coord_t'(1);

    // Inclusive range test used for the sync decodes.
    function automatic logic in_range(input coord_t v,
                                      input coord_t lo,
                                      input coord_t hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// ----------------------------------------------------------------------------
// vga_axis_counter
//   One axis (horizontal or vertical) of the VGA raster. Holds the position
//   counter and decodes the *next* position so the parent can register sync
//   and visible flags that line up with the counter on the same edge.
//
//   Ports
//     clk_i      : pixel clock, rising edge
//     reset_i    : synchronous active-high reset, counter to 0
//     advance_i  : step the counter this edge (wraps TOTAL-1 -> 0)
//     count_o    : current position (registered)
//     wrap_o     : this edge takes the counter from TOTAL-1 to 0
//     sync_o     : next position lies in [SYNC_START, SYNC_END]
//     visible_o  : next position lies below VISIBLE
// ----------------------------------------------------------------------------
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter coord_t TOTAL      = H_TOTAL,
    parameter coord_t VISIBLE    = H_VISIBLE,
    parameter coord_t SYNC_START = H_SYNC_START,
    parameter coord_t SYNC_END   = H_SYNC_END
) (
    input  logic   clk_i,
    input  logic   reset_i,
    input  logic   advance_i,
    output coord_t count_o,
    output logic   wrap_o,
    output logic   sync_o,
    output logic   visible_o
);

    localparam coord_t LAST = TOTAL - coord_t'(1);

    coord_t count_q;
    coord_t count_d;
    logic   at_last;
    logic   illegal;

    always_comb begin
        // NOTE: every output of this block gets a default before any branch,
        // so no path can leave a value unassigned and infer a latch.
        count_d = count_q;
        at_last = (count_q == LAST);
        illegal = (count_q > LAST);
        wrap_o  = advance_i && at_last;

        // An out-of-range count cannot be reached from reset, but if it ever
        // appears it snaps back to 0 on the next edge rather than running on.
        if (illegal) begin
            count_d = '0;
        end else if (advance_i) begin
            count_d = at_last ? '0 : count_q + coord_t'(1);
        end
    end

    // Decodes look at the next position; the parent registers them on the same
    // edge that loads count_q, so flags and counter change together.
    assign sync_o    = in_range(count_d, SYNC_START, SYNC_END);
    assign visible_o = (count_d < VISIBLE);

    always_ff @(posedge clk_i) begin
        // NOTE: state registers use non-blocking assignment so all flops
        // sample their inputs from before the edge, independent of order.
        if (reset_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/vga_timing_gen.sv
// ----------------------------------------------------------------------------
// vga_timing_gen
//   640x480@60 VGA raster timing generator. Two vga_axis_counter instances
//   produce the horizontal and vertical positions; the vertical one steps when
//   the horizontal one wraps. Sync and blank flags are registered from the
//   next-state decodes so they are coherent with DrawX/DrawY.
//
//   Build option:
//     VGA_SYNC_PIPE_EN - when defined, hs/vs/blank pass through one extra
//                        register stage (one cycle later than DrawX/DrawY) to
//                        line up with a one-cycle-registered pixel path.
//                        frame_start and frame_count are never delayed.
//
//   Ports
//     vga_clk     : pixel clock (25 MHz nominal), rising edge
//     reset       : synchronous active-high reset
//     hs          : horizontal sync, active low (DrawX 656..751)
//     vs          : vertical sync, active low (DrawY 490..491)
//     blank       : high in the visible region (DrawX<640 and DrawY<480)
//     DrawX       : horizontal position 0..799
//     DrawY       : vertical position 0..524
//     frame_start : one-cycle pulse when the raster advances to (0,0)
//     frame_count : number of frame starts seen, wraps (FRAME_W bits)
// ----------------------------------------------------------------------------
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int FRAME_W = 8
) (
    input  logic               vga_clk,
    input  logic               reset,
    output logic               hs,
    output logic               vs,
    output logic               blank,
    output logic [9:0]         DrawX,
    output logic [9:0]         DrawY,
    output logic               frame_start,
    output logic [FRAME_W-1:0] frame_count
);

    coord_t h_count;
    coord_t v_count;
    logic   h_wrap;
    logic   v_wrap;
    logic   h_sync_next;
    logic   v_sync_next;
    logic   h_vis_next;
    logic   v_vis_next;

    // Horizontal axis steps every pixel clock.
    vga_axis_counter #(
        .TOTAL      (H_TOTAL),
        .VISIBLE    (H_VISIBLE),
        .SYNC_START (H_SYNC_START),
        .SYNC_END   (H_SYNC_END)
    ) u_h_axis (
        .clk_i     (vga_clk),
        .reset_i   (reset),
        .advance_i (1'b1),
        .count_o   (h_count),
        .wrap_o    (h_wrap),
        .sync_o    (h_sync_next),
        .visible_o (h_vis_next)
    );

    // Vertical axis steps on the same edge the horizontal one wraps.
    vga_axis_counter #(
        .TOTAL      (V_TOTAL),
        .VISIBLE    (V_VISIBLE),
        .SYNC_START (V_SYNC_START),
        .SYNC_END   (V_SYNC_END)
    ) u_v_axis (
        .clk_i     (vga_clk),
        .reset_i   (reset),
        .advance_i (h_wrap),
        .count_o   (v_count),
        .wrap_o    (v_wrap),
        .sync_o    (v_sync_next),
        .visible_o (v_vis_next)
    );

    // ------------------------------------------------------------------
    // Coherent flag stage: loaded from next-state decodes
    // ------------------------------------------------------------------
    logic               hs_q,          hs_d;
    logic               vs_q,          vs_d;
    logic               blank_q,       blank_d;
    logic               frame_start_q, frame_start_d;
    logic [FRAME_W-1:0] frame_count_q, frame_count_d;

    always_comb begin
        hs_d          = ~h_sync_next;
        vs_d          = ~v_sync_next;
        blank_d       = h_vis_next & v_vis_next;
        // Both axes wrapping together is exactly the step onto (0,0).
        frame_start_d = h_wrap & v_wrap;
        frame_count_d = frame_count_q;
        if (frame_start_d) begin
            frame_count_d = frame_count_q + FRAME_W'(1);
        end
    end

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            // Pixel (0,0) right after reset is deliberately blanked.
            hs_q          <= 1'b1;
            vs_q          <= 1'b1;
            blank_q       <= 1'b0;
            frame_start_q <= 1'b0;
            frame_count_q <= '0;
        end else begin
            hs_q          <= hs_d;
            vs_q          <= vs_d;
            blank_q       <= blank_d;
            frame_start_q <= frame_start_d;
            frame_count_q <= frame_count_d;
        end
    end

`ifdef VGA_SYNC_PIPE_EN
    // ------------------------------------------------------------------
    // Extra delay on sync/blank only, matching a registered pixel path
    // ------------------------------------------------------------------
    logic hs_pipe_q;
    logic vs_pipe_q;
    logic blank_pipe_q;

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            hs_pipe_q    <= 1'b1;
            vs_pipe_q    <= 1'b1;
            blank_pipe_q <= 1'b0;
        end else begin
            hs_pipe_q    <= hs_q;
            vs_pipe_q    <= vs_q;
            blank_pipe_q <= blank_q;
        end
    end

    assign hs    = hs_pipe_q;
    assign vs    = vs_pipe_q;
    assign blank = blank_pipe_q;
`else
    assign hs    = hs_q;
    assign vs    = vs_q;
    assign blank = blank_q;
`endif

    assign DrawX       = h_count;
    assign DrawY       = v_count;
    assign frame_start = frame_start_q;
    assign frame_count = frame_count_q;

endmodule
